// File: rtl/debounce_sync.sv
`timescale 1ns/1ps
// debounce_sync: multi-flop synchronizer followed by a consecutive-cycle stability counter.
// Produces a debounced level plus one-cycle rise/fall pulses, all registered in the clk domain.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic D,
  output logic Q,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Terminal count: Q flips on the edge that would otherwise advance past this value.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_q;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_busy;

  logic                   w_s;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_flip;

  assign w_s = r_sync[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], D};
    end
  end

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    w_cnt_next = '0;
    w_flip     = 1'b0;
    if (w_s != r_q) begin
      if (r_cnt == LAST_CNT) begin
        w_flip = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  // A single agreeing cycle drops the count to zero, so partial glitches are never remembered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_q    <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      if (w_flip) begin
        r_q <= w_s;
      end
      r_rise <= w_flip & w_s;
      r_fall <= w_flip & ~w_s;
      r_busy <= (w_cnt_next != '0);
    end
  end

  assign Q    = r_q;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;

endmodule
